// File: rtl/motor_ramp_sched.sv
// motor_ramp_sched
//   Slew-rate limited command sequencer in front of the motor controller.
//   Each wheel channel ramps toward its latched target by at most STEP per
//   update tick. A sign reversal first ramps to zero and then holds a brake
//   interval of BRAKE_CYC cycles. A level-sensitive estop returns everything
//   to the post-reset state but leaves the tick phase running.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   cmd_vld    target command valid
//   cmd_lft    signed left target
//   cmd_rht    signed right target
//   cmd_rdy    command accepted on cmd_vld & cmd_rdy (equals ~estop)
//   estop      emergency stop, level-sensitive
//   lft, rht   registered signed drive values to the motor controller
//   busy       at least one channel ramping or braking
//   at_target  both channels holding with drive equal to target
module motor_ramp_sched #(
  parameter int STEP      = 16,
  parameter int TICK_DIV  = 1024,
  parameter int BRAKE_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_vld,
  input  logic signed [10:0] cmd_lft,
  input  logic signed [10:0] cmd_rht,
  output logic               cmd_rdy,
  input  logic               estop,
  output logic signed [10:0] lft,
  output logic signed [10:0] rht,
  output logic               busy,
  output logic               at_target
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int BRK_W = $clog2(BRAKE_CYC + 1);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [BRK_W-1:0]  BRK_LOAD  = BRK_W'(BRAKE_CYC);
  localparam logic signed [11:0] STEP_S   = 12'(STEP);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_BRAKE = 2'd2
  } ch_state_t;

  logic [CNT_W-1:0]  tick_cnt_r;
  logic              tick_s;
  logic              accept_s;

  logic signed [10:0] cmd_s      [2];
  logic signed [10:0] tgt_r      [2];
  logic signed [10:0] cur_r      [2];
  ch_state_t          st_r       [2];
  logic [BRK_W-1:0]   brk_r      [2];

  logic signed [10:0] tgt_nxt_s  [2];
  logic signed [10:0] cur_nxt_s  [2];
  logic signed [10:0] step_s     [2];
  ch_state_t          st_nxt_s   [2];
  logic [BRK_W-1:0]   brk_nxt_s  [2];
  logic               busy_nxt_s;
  logic               at_tgt_nxt_s;
  logic               busy_r;
  logic               at_target_r;

  // -1024 has no positive counterpart, so it is pulled in to -1023.
  function automatic logic signed [10:0] clamp_cmd(input logic signed [10:0] v);
    if (v == 11'sh400) clamp_cmd = 11'sh401;
    else               clamp_cmd = v;
  endfunction

  function automatic logic is_reversal(input logic signed [10:0] cur_v,
                                       input logic signed [10:0] tgt_v);
    is_reversal = (cur_v != 11'sd0) && (tgt_v != 11'sd0) && (cur_v[10] != tgt_v[10]);
  endfunction

  // One tick worth of movement; 12-bit intermediates keep tgt-cur exact.
  function automatic logic signed [10:0] ramp_step(input logic signed [10:0] cur_v,
                                                   input logic signed [10:0] tgt_v);
    logic signed [11:0] c_v, t_v, d_v, r_v;
    c_v = {cur_v[10], cur_v};
    t_v = {tgt_v[10], tgt_v};
    d_v = t_v - c_v;
    if (is_reversal(cur_v, tgt_v)) begin
      if (c_v > 12'sd0) begin
        if (c_v > STEP_S) r_v = c_v - STEP_S;
        else              r_v = 12'sd0;
      end else begin
        if (c_v < -STEP_S) r_v = c_v + STEP_S;
        else               r_v = 12'sd0;
      end
    end else if (d_v > STEP_S) begin
      r_v = c_v + STEP_S;
    end else if (d_v < -STEP_S) begin
      r_v = c_v - STEP_S;
    end else begin
      r_v = t_v;
    end
    ramp_step = r_v[10:0];
  endfunction

  assign tick_s    = (tick_cnt_r == TICK_LAST);
  assign cmd_rdy   = ~estop;
  assign accept_s  = cmd_vld & ~estop;
  assign cmd_s[0]  = cmd_lft;
  assign cmd_s[1]  = cmd_rht;
  assign lft       = cur_r[0];
  assign rht       = cur_r[1];
  assign busy      = busy_r;
  assign at_target = at_target_r;

  // Free-running tick divider; only rst restarts its phase.
  always_ff @(posedge clk) begin
    if (rst)         tick_cnt_r <= {CNT_W{1'b0}};
    else if (tick_s) tick_cnt_r <= {CNT_W{1'b0}};
    else             tick_cnt_r <= tick_cnt_r + CNT_W'(1);
  end

  // Per-channel next state: target load, HOLD/RAMP/BRAKE transitions.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      tgt_nxt_s[c] = tgt_r[c];
      cur_nxt_s[c] = cur_r[c];
      st_nxt_s[c]  = st_r[c];
      brk_nxt_s[c] = brk_r[c];
      step_s[c]    = ramp_step(cur_r[c], tgt_r[c]);

      if (accept_s) tgt_nxt_s[c] = clamp_cmd(cmd_s[c]);
      else          tgt_nxt_s[c] = tgt_r[c];

      case (st_r[c])
        ST_HOLD: begin
          if (cur_r[c] != tgt_r[c]) st_nxt_s[c] = ST_RAMP;
          else                      st_nxt_s[c] = ST_HOLD;
        end
        ST_RAMP: begin
          if (tick_s) begin
            cur_nxt_s[c] = step_s[c];
            if (is_reversal(cur_r[c], tgt_r[c])) begin
              // Only a reversal that reaches zero starts the brake.
              if (step_s[c] == 11'sd0) begin
                st_nxt_s[c]  = ST_BRAKE;
                brk_nxt_s[c] = BRK_LOAD;
              end else begin
                st_nxt_s[c]  = ST_RAMP;
              end
            end else if (step_s[c] == tgt_r[c]) begin
              st_nxt_s[c] = ST_HOLD;
            end else begin
              st_nxt_s[c] = ST_RAMP;
            end
          end else begin
            st_nxt_s[c] = ST_RAMP;
          end
        end
        ST_BRAKE: begin
          // Counter runs every cycle regardless of tick; exit when it hits zero.
          cur_nxt_s[c] = 11'sd0;
          if (brk_r[c] <= BRK_W'(1)) begin
            brk_nxt_s[c] = {BRK_W{1'b0}};
            if (tgt_r[c] != 11'sd0) st_nxt_s[c] = ST_RAMP;
            else                    st_nxt_s[c] = ST_HOLD;
          end else begin
            brk_nxt_s[c] = brk_r[c] - BRK_W'(1);
            st_nxt_s[c]  = ST_BRAKE;
          end
        end
        default: begin
          st_nxt_s[c]  = ST_HOLD;
          cur_nxt_s[c] = 11'sd0;
          brk_nxt_s[c] = {BRK_W{1'b0}};
        end
      endcase
    end
  end

  // Status flags derived from the next state so they align with lft/rht.
  always_comb begin
    busy_nxt_s   = (st_nxt_s[0] != ST_HOLD) || (st_nxt_s[1] != ST_HOLD);
    at_tgt_nxt_s = (st_nxt_s[0] == ST_HOLD) && (cur_nxt_s[0] == tgt_nxt_s[0]) &&
                   (st_nxt_s[1] == ST_HOLD) && (cur_nxt_s[1] == tgt_nxt_s[1]);
  end

  // Channel registers; estop behaves like reset except for the tick phase.
  always_ff @(posedge clk) begin
    if (rst || estop) begin
      for (int c = 0; c < 2; c++) begin
        tgt_r[c] <= 11'sd0;
        cur_r[c] <= 11'sd0;
        st_r[c]  <= ST_HOLD;
        brk_r[c] <= {BRK_W{1'b0}};
      end
      busy_r      <= 1'b0;
      at_target_r <= 1'b1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        tgt_r[c] <= tgt_nxt_s[c];
        cur_r[c] <= cur_nxt_s[c];
        st_r[c]  <= st_nxt_s[c];
        brk_r[c] <= brk_nxt_s[c];
      end
      busy_r      <= busy_nxt_s;
      at_target_r <= at_tgt_nxt_s;
    end
  end

endmodule

// File: tb/tb_motor_ramp_sched.sv
// Testbench for motor_ramp_sched: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model built on integer arithmetic.
module tb_motor_ramp_sched;

  localparam int STEP      = 16;
  localparam int TICK_DIV  = 4;
  localparam int BRAKE_CYC = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_vld;
  logic signed [10:0] cmd_lft;
  logic signed [10:0] cmd_rht;
  logic               cmd_rdy;
  logic               estop;
  logic signed [10:0] lft;
  logic signed [10:0] rht;
  logic               busy;
  logic               at_target;

  motor_ramp_sched #(.STEP(STEP), .TICK_DIV(TICK_DIV), .BRAKE_CYC(BRAKE_CYC)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_lft(cmd_lft), .cmd_rht(cmd_rht),
    .cmd_rdy(cmd_rdy), .estop(estop), .lft(lft), .rht(rht), .busy(busy),
    .at_target(at_target)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fails = 0;

  // Model: drive, target, remaining brake cycles, and a "still moving" flag.
  int m_cur [2];
  int m_tgt [2];
  int m_brk [2];
  bit m_mov [2];
  int m_cnt;

  bit rec_on;
  int last_lft;
  int lft_hist [$];
  int bad_rht;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int isgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int clampv(input int v);
    return (v == -1024) ? -1023 : v;
  endfunction

  task automatic model_step();
    bit tick;
    int cmdv [2];
    int nt, d, mag;
    cmdv[0] = $signed(cmd_lft);
    cmdv[1] = $signed(cmd_rht);
    if (rst) m_cnt = 0;
    tick  = (m_cnt == TICK_DIV - 1);
    if (!rst) m_cnt = (m_cnt + 1) % TICK_DIV;
    for (int c = 0; c < 2; c++) begin
      if (rst || estop) begin
        m_cur[c] = 0; m_tgt[c] = 0; m_brk[c] = 0; m_mov[c] = 0;
      end else begin
        nt = (cmd_vld) ? clampv(cmdv[c]) : m_tgt[c];
        if (m_brk[c] > 0) begin
          m_brk[c]--;
          if (m_brk[c] == 0) m_mov[c] = (m_tgt[c] != 0);
        end else if (m_mov[c]) begin
          if (tick) begin
            if (m_cur[c] != 0 && m_tgt[c] != 0 && isgn(m_cur[c]) != isgn(m_tgt[c])) begin
              mag = (iabs(m_cur[c]) < STEP) ? iabs(m_cur[c]) : STEP;
              m_cur[c] = m_cur[c] - isgn(m_cur[c]) * mag;
              if (m_cur[c] == 0) begin
                m_brk[c] = BRAKE_CYC;
                m_mov[c] = 0;
              end
            end else begin
              d = m_tgt[c] - m_cur[c];
              if (iabs(d) <= STEP) m_cur[c] = m_tgt[c];
              else                 m_cur[c] = m_cur[c] + isgn(d) * STEP;
              if (m_cur[c] == m_tgt[c]) m_mov[c] = 0;
            end
          end
        end else if (m_cur[c] != m_tgt[c]) begin
          m_mov[c] = 1;
        end
        m_tgt[c] = nt;
      end
    end
  endtask

  task automatic compare_all();
    bit eb, ea;
    eb = m_mov[0] || m_mov[1] || (m_brk[0] > 0) || (m_brk[1] > 0);
    ea = !eb && (m_cur[0] == m_tgt[0]) && (m_cur[1] == m_tgt[1]);
    check("lft", $signed(lft), m_cur[0]);
    check("rht", $signed(rht), m_cur[1]);
    check("busy", busy, eb);
    check("at_target", at_target, ea);
    check("cmd_rdy", cmd_rdy, !estop);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (rec_on && $signed(lft) != last_lft) lft_hist.push_back($signed(lft));
    last_lft = $signed(lft);
    if (rht == 11'h400) bad_rht++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input int l, input int r);
    cmd_vld = 1'b1;
    cmd_lft = l[10:0];
    cmd_rht = r[10:0];
    cycle();
    cmd_vld = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int exp_q [$]);
    check({tag, "_len"}, lft_hist.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < lft_hist.size(); i++)
      check(tag, lft_hist[i], exp_q[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc, r;
    for (int c = 0; c < 2; c++) begin
      m_cur[c] = 0; m_tgt[c] = 0; m_brk[c] = 0; m_mov[c] = 0;
    end
    m_cnt = 0; rec_on = 0; last_lft = 0; bad_rht = 0;
    rst = 1'b1; estop = 1'b0; cmd_vld = 1'b0; cmd_lft = 11'sd0; cmd_rht = 11'sd0;
    run(2);
    rst = 1'b0;
    check("rst_at_target", at_target, 1);
    check("rst_busy", busy, 0);

    // Ramp up to 100 on the left channel.
    lft_hist.delete(); rec_on = 1;
    send(100, 0);
    run(40);
    rec_on = 0;
    check_seq("ramp_seq", '{16, 32, 48, 64, 80, 96, 100});
    check("ramp_at_target", at_target, 1);
    check("ramp_rht", $signed(rht), 0);

    // Reversal 48 -> -48 through a brake interval.
    send(48, 0);
    run(20);
    lft_hist.delete(); rec_on = 1;
    send(-48, 0);
    run(60);
    rec_on = 0;
    check_seq("rev_seq", '{32, 16, 0, -16, -32, -48});

    // Clamp of -1024 on the right channel.
    send(0, -1024);
    run(64 * TICK_DIV + 12);
    check("clamp_rht", $signed(rht), -1023);
    check("clamp_never_400", bad_rht, 0);

    // Mid-ramp reset.
    send(200, 200);
    run(10);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    check("rst2_lft", $signed(lft), 0);
    check("rst2_at_target", at_target, 1);
    check("rst2_cmd_rdy", cmd_rdy, 1);

    // Estop at lft = 64 with a command presented in the same cycle.
    send(200, 0);
    for (int i = 0; i < 100 && $signed(lft) != 64; i++) cycle();
    check("wait_lft64", $signed(lft), 64);
    estop = 1'b1; cmd_vld = 1'b1; cmd_lft = 11'sd500; cmd_rht = 11'sd300;
    cycle();
    check("estop_lft", $signed(lft), 0);
    check("estop_rdy", cmd_rdy, 0);
    estop = 1'b0; cmd_vld = 1'b0;
    cycle();
    check("estop_at_target", at_target, 1);
    run(12);
    check("estop_dropped", $signed(lft), 0);

    // Retarget to 0 while braking: the brake still runs its full length.
    send(32, 0);
    run(20);
    send(-32, 0);
    for (int i = 0; i < 40 && m_brk[0] == 0; i++) cycle();
    check("brake_lft", $signed(lft), 0);
    bc = 0;
    if (busy) bc++;
    send(0, 0);
    if (busy) bc++;
    for (int i = 0; i < 30 && busy; i++) begin
      cycle();
      if (busy) bc++;
    end
    check("brake_len", bc, BRAKE_CYC);
    run(4);
    check("brake_done_lft", $signed(lft), 0);
    check("brake_done_busy", busy, 0);

    // Randomized traffic, compared every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (estop) estop = ($urandom_range(0, 1) == 0);
      else       estop = (r < 2);
      rst = (r == 50);
      cmd_vld = ($urandom_range(0, 19) == 0);
      for (int c = 0; c < 2; c++) begin
        int v;
        case ($urandom_range(0, 3))
          0:       v = -1024;
          1:       v = $urandom_range(0, 2047) - 1024;
          2:       v = $urandom_range(0, 128) - 64;
          default: v = 0;
        endcase
        if (c == 0) cmd_lft = v[10:0];
        else        cmd_rht = v[10:0];
      end
      cycle();
    end
    rst = 1'b0; estop = 1'b0; cmd_vld = 1'b0;
    check("rand_never_400", bad_rht, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/motor_ramp_sched.md
# motor_ramp_sched

Command sequencer placed in front of the motor controller's signed 11-bit `lft`/`rht` inputs. It accepts target wheel commands over a valid/ready handshake and slews each channel toward its target at a bounded rate per update tick. On a sign reversal it ramps to zero and holds a brake interval before driving in the new direction. It also provides an emergency stop. Its `lft`/`rht` outputs connect directly to the motor controller's inputs.

## Interface
- `STEP`, 16: maximum magnitude change per channel per tick (1..1023).
- `TICK_DIV`, 1024: clock cycles per update tick (≥2).
- `BRAKE_CYC`, 4096: cycles a channel holds 0 (brake) after ramping down for a reversal (≥1).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `cmd_vld`  in  1  target command valid.
- `cmd_lft`  in  11  signed two's-complement left target.
- `cmd_rht`  in  11  signed two's-complement right target.
- `cmd_rdy`  out  1  command accepted when `cmd_vld & cmd_rdy`; equals `~estop`.
- `estop`  in  1  emergency stop, level-sensitive.
- `lft`  out  11  signed left drive to the motor controller, registered.
- `rht`  out  11  signed right drive to the motor controller, registered.
- `busy`  out  1  at least one channel is in RAMP or BRAKE.
- `at_target`  out  1  both channels are in HOLD with `cur == tgt`.

## Operation
- Reset is synchronous and active-high. It forces `lft = rht = 0`, both targets to 0, both channel states to HOLD, and the tick counter to 0. After reset, `busy = 0` and `at_target = 1`.
- Tick counter: counts 0..TICK_DIV-1 and wraps. `tick` is asserted in the cycle where the count is TICK_DIV-1. The counter free-runs and is not restarted by commands.
- Accept: on `cmd_vld & cmd_rdy`, each target register loads the clamped command. A target of -1024 (11'h400) is clamped to -1023. This is the only clamp.
- A new command replaces the targets at any time, including mid-ramp and mid-brake.
- Each channel runs an independent FSM: HOLD, RAMP, BRAKE.
  - HOLD → RAMP: on the cycle after `cur != tgt`.
  - RAMP, on each tick, updates `cur` as follows:
    - Reversal (`cur != 0`, `tgt != 0`, signs differ): step toward 0 by min(STEP, |cur|).
    - Otherwise, if |tgt − cur| ≤ STEP: set `cur = tgt`.
    - Otherwise: `cur += sign(tgt − cur)·STEP`.
  - RAMP → BRAKE: a reversal step lands exactly on 0. The brake counter loads BRAKE_CYC.
  - RAMP → HOLD: `cur == tgt` after a non-reversal update.
  - BRAKE: `cur` stays 0 and the counter decrements every cycle, independent of tick. At 0, go to RAMP if `tgt != 0`, else HOLD.
  - A target change during BRAKE does not shorten the brake.
- Arithmetic uses 12-bit signed intermediates, so no overflow is possible. Outputs always stay within [-1023, 1023].
- `estop` high takes effect on the next clock edge and overrides ticks and accepts:
  - `lft = rht = 0` and targets = 0.
  - Both FSMs go to HOLD and brake counters clear.
  - `cmd_rdy = 0`, so any command presented in the same cycle is dropped.
  - The tick counter keeps running.
- After `estop` deasserts, the block is in the post-reset state, except that the tick counter phase is preserved.

## Timing
- Accept at edge N: the target is visible internally after edge N. `busy` rises one cycle later (HOLD → RAMP).
- A RAMP update occurs at the edge ending a tick cycle. The new `lft`/`rht` is visible the following cycle.
- First output change occurs ≤ TICK_DIV+1 cycles after accept.
- Full ramp from 0 to T: ceil(|T|/STEP) ticks.
- Reversal from +A to −B: ceil(A/STEP) ticks down, then BRAKE_CYC cycles at 0, then ramp-up resumes on the first tick after BRAKE exits.
- `at_target` and `busy` are registered from state and update in the same cycle as the outputs.
- Outputs never change except on a tick edge, on BRAKE exit (state only), on `estop`, or on `rst`.

## Test plan
Bench parameters: STEP=16, TICK_DIV=4, BRAKE_CYC=8.
- Reset: assert `rst` 2 cycles mid-ramp → `lft = rht = 0`, `busy = 0`, `at_target = 1`, `cmd_rdy = 1` on the next cycle.
- Ramp up: `cmd_lft = 100`, `cmd_rht = 0` → `lft` sequence 16, 32, 48, 64, 80, 96, 100 on 7 consecutive ticks; `rht` stays 0; `at_target` rises after the last tick.
- Reversal: settle at 48, then command -48 → `lft` 32, 16, 0, held at 0 for 8 cycles, then -16, -32, -48 on the next ticks; `busy` stays high throughout.
- Clamp and negative ramp: `cmd_rht = 11'h400` → `rht` settles at -1023 (11'h401), never 11'h400, after 64 ticks.
- Estop: assert `estop` mid-ramp at `lft = 64` with `cmd_vld` high in the same cycle → next cycle `lft = 0`, `cmd_rdy = 0`, command dropped. After release, `at_target = 1`.
- Retarget mid-brake: during BRAKE, command 0 → brake completes all 8 cycles, then HOLD with `lft = 0`, `busy = 0`.
